// File: rtl/datapath_pkg.sv
// Shared opcodes and FSM encodings for the single-bus datapath.
// Imported by the ALU and the sequencer top.
package datapath_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SHR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_NEG = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S_Y  = 3'd1,
        S_Z  = 3'd2,
        S_WB = 3'd3,
        S_HI = 3'd4
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/alu_param.sv
// Combinational ALU: Y op bus -> double-width result {ZHigh,ZLow}.
// Upper half is zero for every op except signed MUL.
module alu_param
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   y,
    input  logic [DATA_W-1:0]   bus,
    input  logic [3:0]          op,
    output logic [2*DATA_W-1:0] res
);

    localparam int SW = $clog2(DATA_W);

    logic [SW-1:0]       amt;
    logic [SW:0]         inv;
    logic [DATA_W-1:0]   ror;
    logic [DATA_W-1:0]   rol;
    logic [2*DATA_W-1:0] y_sx;
    logic [2*DATA_W-1:0] b_sx;
    logic [2*DATA_W-1:0] prod;

    assign amt = bus[SW-1:0];
    assign inv = (SW+1)'(DATA_W) - {1'b0, amt};
    assign ror = (y >> amt) | (y << inv);
    assign rol = (y << amt) | (y >> inv);

    // Low 2W bits of the sign-extended product equal the signed product.
    assign y_sx = {{DATA_W{y[DATA_W-1]}}, y};
    assign b_sx = {{DATA_W{bus[DATA_W-1]}}, bus};
    assign prod = y_sx * b_sx;

    always_comb begin
        res = '0;
        unique case (op)
            OP_ADD:  res[DATA_W-1:0] = y + bus;
            OP_SUB:  res[DATA_W-1:0] = y - bus;
            OP_AND:  res[DATA_W-1:0] = y & bus;
            OP_OR:   res[DATA_W-1:0] = y | bus;
            OP_SHR:  res[DATA_W-1:0] = y >> amt;
            OP_SHL:  res[DATA_W-1:0] = y << amt;
            OP_ROR:  res[DATA_W-1:0] = ror;
            OP_ROL:  res[DATA_W-1:0] = rol;
            OP_NEG:  res[DATA_W-1:0] = -bus;
            OP_NOT:  res[DATA_W-1:0] = ~bus;
            OP_MUL:  res = prod;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus register-file datapath sequenced by a small FSM:
// operand fetch into Y, ALU into Z, writeback (or HI/LO for MUL).
module bus_datapath_seq
    import datapath_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [AW-1:0]     ra,
    input  logic [AW-1:0]     rb,
    input  logic [AW-1:0]     rc,
    input  logic              ext_we,
    input  logic [AW-1:0]     ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    state_e state_q, state_d;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic [3:0]        op_q, op_d;
    logic [AW-1:0]     ra_q, ra_d;
    logic [AW-1:0]     rb_q, rb_d;
    logic [AW-1:0]     rc_q, rc_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] zh_q, zh_d;
    logic [DATA_W-1:0] zl_q, zl_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0]   bus;
    logic [2*DATA_W-1:0] alu_res;
    logic                accept;
    logic                ld_y, ld_z, ld_lo, ld_hi;
    logic                wr_r, fin, set_err;

    assign accept = (state_q == IDLE) && start;

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .y   (y_q),
        .bus (bus),
        .op  (op_q),
        .res (alu_res)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = S_Y;
            S_Y:     state_d = S_Z;
            S_Z:     state_d = S_WB;
            S_WB:    state_d = (op_q == OP_MUL) ? S_HI : IDLE;
            S_HI:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus     = '0;
        ld_y    = 1'b0;
        ld_z    = 1'b0;
        ld_lo   = 1'b0;
        ld_hi   = 1'b0;
        wr_r    = 1'b0;
        fin     = 1'b0;
        set_err = 1'b0;
        unique case (state_q)
            IDLE: ;
            S_Y: begin
                bus  = regs_q[rb_q];
                ld_y = 1'b1;
            end
            S_Z: begin
                bus  = regs_q[rc_q];
                ld_z = 1'b1;
            end
            S_WB: begin
                bus = zl_q;
                if (op_q == OP_MUL) begin
                    ld_lo = 1'b1;
                end else begin
                    fin     = 1'b1;
                    wr_r    = op_legal(op_q);
                    set_err = !op_legal(op_q);
                end
            end
            S_HI: begin
                bus   = zh_q;
                ld_hi = 1'b1;
                fin   = 1'b1;
            end
            default: ;
        endcase
    end

    // ext_we and writeback never collide: one is IDLE-only, the other S_WB.
    always_comb begin
        regs_d = regs_q;
        if ((state_q == IDLE) && ext_we) regs_d[ext_addr] = ext_data;
        if (wr_r) regs_d[ra_q] = bus;
        regs_d[0] = '0;

        op_d = accept ? op : op_q;
        ra_d = accept ? ra : ra_q;
        rb_d = accept ? rb : rb_q;
        rc_d = accept ? rc : rc_q;

        y_d  = ld_y ? bus : y_q;
        zh_d = ld_z ? alu_res[2*DATA_W-1:DATA_W] : zh_q;
        zl_d = ld_z ? alu_res[DATA_W-1:0] : zl_q;
        lo_d = ld_lo ? bus : lo_q;
        hi_d = ld_hi ? bus : hi_q;

        done_d = fin;
        err_d  = err_q;
        if (set_err) err_d = 1'b1;
        if (accept)  err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            op_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            rc_q   <= '0;
            y_q    <= '0;
            zh_q   <= '0;
            zl_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            op_q   <= op_d;
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            rc_q   <= rc_d;
            y_q    <= y_d;
            zh_q   <= zh_d;
            zl_q   <= zl_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign dbg_data = regs_q[dbg_addr];
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq: ALU ops, MUL, R0, illegal op,
// busy collisions, same-cycle load+start, aliasing and reset abort.
module tb_bus_datapath_seq;

    localparam int W  = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    op = '0;
    logic [AW-1:0] ra = '0, rb = '0, rc = '0;
    logic          ext_we = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [W-1:0]  ext_data = '0;
    logic [AW-1:0] dbg_addr = '0;
    logic [W-1:0]  dbg_data;
    logic          busy, done, err;
    logic [W-1:0]  hi_out, lo_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_datapath_seq #(.DATA_W(W), .NUM_REGS(16)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .op       (op),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc),
        .ext_we   (ext_we),
        .ext_addr (ext_addr),
        .ext_data (ext_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a,
                          input logic [W-1:0] expv);
        dbg_addr = a;
        #1;
        chk(tag, 64'(dbg_data), 64'(expv));
    endtask

    task automatic ext_load(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        ext_we   = 1'b1;
        ext_addr = a;
        ext_data = d;
        @(negedge clk);
        ext_we   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_done"}, 64'(done), 64'd1);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] o,
                           input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] c, input int exp_lat);
        @(negedge clk);
        start = 1'b1;
        op = o;
        ra = a;
        rb = b;
        rc = c;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(tag, exp_lat);
    endtask

    initial begin
        int dn;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        rd_chk("rst_r5", 4'd5, 32'h0);
        @(negedge clk);
        clr = 1'b1;

        ext_load(4'd2, 32'd5);
        ext_load(4'd3, 32'd7);
        rd_chk("ld_r2", 4'd2, 32'd5);
        run_cmd("add", 4'd0, 4'd1, 4'd2, 4'd3, 3);
        rd_chk("add_r1", 4'd1, 32'd12);
        chk("add_err", 64'(err), 64'd0);

        ext_load(4'd2, 32'h0000_000F);
        ext_load(4'd3, 32'd4);
        run_cmd("ror", 4'd6, 4'd1, 4'd2, 4'd3, 3);
        rd_chk("ror_r1", 4'd1, 32'hF000_0000);
        run_cmd("rol", 4'd7, 4'd1, 4'd2, 4'd3, 3);
        rd_chk("rol_r1", 4'd1, 32'h0000_00F0);
        run_cmd("sub", 4'd1, 4'd9, 4'd3, 4'd2, 3);
        rd_chk("sub_r9", 4'd9, 32'hFFFF_FFF5);

        ext_load(4'd2, 32'hFFFF_FFFE);
        ext_load(4'd3, 32'd3);
        run_cmd("mul", 4'd10, 4'd1, 4'd2, 4'd3, 4);
        chk("mul_hi", 64'(hi_out), 64'hFFFF_FFFF);
        chk("mul_lo", 64'(lo_out), 64'hFFFF_FFFA);
        rd_chk("mul_r1", 4'd1, 32'h0000_00F0);

        run_cmd("r0", 4'd0, 4'd0, 4'd2, 4'd3, 3);
        rd_chk("r0_zero", 4'd0, 32'h0);

        run_cmd("ill", 4'd12, 4'd1, 4'd2, 4'd3, 3);
        chk("ill_err", 64'(err), 64'd1);
        rd_chk("ill_r1", 4'd1, 32'h0000_00F0);
        chk("ill_hi", 64'(hi_out), 64'hFFFF_FFFF);
        chk("ill_lo", 64'(lo_out), 64'hFFFF_FFFA);
        repeat (3) @(negedge clk);
        chk("err_hold", 64'(err), 64'd1);

        // Busy collisions: second start and ext_we during S_Y/S_Z
        start = 1'b1;
        op = 4'd0;
        ra = 4'd4;
        rb = 4'd2;
        rc = 4'd3;
        @(negedge clk);
        chk("col_errclr", 64'(err), 64'd0);
        chk("col_busy", 64'(busy), 64'd1);
        op = 4'd3;
        ra = 4'd5;
        ext_we = 1'b1;
        ext_addr = 4'd6;
        ext_data = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        ext_we = 1'b0;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("col_ndone", 64'(dn), 64'd1);
        rd_chk("col_r4", 4'd4, 32'd1);
        rd_chk("col_r5", 4'd5, 32'd0);
        rd_chk("col_r6", 4'd6, 32'd0);

        // ext_we and start in the same IDLE cycle
        @(negedge clk);
        ext_we = 1'b1;
        ext_addr = 4'd7;
        ext_data = 32'd100;
        start = 1'b1;
        op = 4'd0;
        ra = 4'd8;
        rb = 4'd7;
        rc = 4'd7;
        @(negedge clk);
        ext_we = 1'b0;
        start = 1'b0;
        wait_done("same", 3);
        rd_chk("same_r8", 4'd8, 32'd200);
        rd_chk("same_r7", 4'd7, 32'd100);

        run_cmd("alias", 4'd0, 4'd7, 4'd7, 4'd7, 3);
        rd_chk("alias_r7", 4'd7, 32'd200);

        // Reset during S_Z
        @(negedge clk);
        start = 1'b1;
        op = 4'd0;
        ra = 4'd1;
        rb = 4'd2;
        rc = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("abt_busy", 64'(busy), 64'd0);
        chk("abt_done", 64'(done), 64'd0);
        chk("abt_hi", 64'(hi_out), 64'd0);
        chk("abt_lo", 64'(lo_out), 64'd0);
        rd_chk("abt_r7", 4'd7, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("abt_quiet", 64'(dn), 64'd0);
        rd_chk("abt_r1", 4'd1, 32'd0);
        chk("abt_err", 64'(err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_datapath_seq.md
BUS_DATAPATH_SEQ -- requirements
Module: bus_datapath_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath/register width (power of two, >=8).
REQ-002 SHALL have parameter NUM_REGS, default 16, general registers R0..R(NUM_REGS-1); AW = clog2(NUM_REGS).
REQ-003 SHALL have ports clk (input, 1, single clock) and clr (input, 1, asynchronous active-low reset).
REQ-004 SHALL have the ALU command ports:
- start: input, 1, command request.
- op: input, 4, operation code.
- ra: input, AW, destination register.
- rb: input, AW, first operand register.
- rc: input, AW, second operand register.
REQ-005 SHALL have the external load port:
- ext_we: input, 1, external register write enable.
- ext_addr: input, AW, write address.
- ext_data: input, DATA_W, write data.
REQ-006 SHALL have the debug read port: dbg_addr (input, AW) and dbg_data (output, DATA_W, combinational read of R[dbg_addr]).
REQ-007 SHALL have status outputs busy (1), done (1), err (1), hi_out (DATA_W), lo_out (DATA_W).

Function
REQ-008 Internal registers SHALL be: R[], Y, ZHigh, ZLow, HI, LO, latched op/ra/rb/rc, and the state register; one shared internal bus.
REQ-009 R0 SHALL always read as 0; writes to R0 SHALL be discarded.
REQ-010 The state machine SHALL have states IDLE, S_Y, S_Z, S_WB and S_HI.
REQ-011 IDLE with start=1 SHALL latch op/ra/rb/rc and go to S_Y; start outside IDLE SHALL be ignored.
REQ-012 S_Y SHALL drive bus=R[rb], load Y on the clock edge, and go to S_Z.
REQ-013 S_Z SHALL drive bus=R[rc], load {ZHigh,ZLow} with ALU(Y,bus) (2*DATA_W bits), and go to S_WB.
REQ-014 S_WB SHALL drive bus=ZLow; for non-MUL ops it SHALL write R[ra] and return to IDLE.
REQ-015 S_WB for MUL SHALL load LO from ZLow and go to S_HI; S_HI SHALL load HI from ZHigh and return to IDLE.
REQ-016 ALU opcodes SHALL be (ZHigh=0 unless stated):
- 0 ADD, 1 SUB, 2 AND, 3 OR.
- 4 SHR (logical), 5 SHL, 6 ROR, 7 ROL; shift/rotate amount = bus[clog2(DATA_W)-1:0].
- 8 NEG (-bus), 9 NOT (~bus).
- 10 MUL: signed Y*bus, full 2*DATA_W product.
REQ-017 ADD/SUB SHALL wrap modulo 2^DATA_W, with no carry kept.
REQ-018 Opcodes 11-15 SHALL perform no register, HI or LO write and SHALL set err=1 together with done.
REQ-019 done SHALL be a registered single-cycle pulse, asserted in the first cycle back in IDLE after a command.
- Latency from the start-sampling edge: 3 cycles for non-MUL, 4 cycles for MUL.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 err SHALL hold its value until the next accepted start, which clears it.
REQ-022 ext_we SHALL write R[ext_addr] only when state=IDLE; it SHALL be ignored while busy.
REQ-023 ext_we and start in the same IDLE cycle SHALL both take effect; operand reads then see the new value.
REQ-024 ra, rb and rc MAY alias; reads of R[ra] SHALL return the old value until the write edge in S_WB.
REQ-025 hi_out and lo_out SHALL continuously reflect HI and LO.

Reset
REQ-026 clr=0 SHALL asynchronously clear all R[], Y, ZHigh, ZLow, HI, LO and the latched fields to 0, force state=IDLE, and force busy=done=err=0.
REQ-027 Reset mid-command SHALL abort the command with no writeback and no done pulse.

Structure
REQ-028 Opcode constants and state encodings SHALL reside in a shared package, datapath_pkg.
REQ-029 The ALU SHALL be a separate combinational sub-module, alu_param, parametrised by DATA_W, taking Y, bus and op and producing the 2*DATA_W result.

Verification
REQ-030 The bench SHALL cover the following directed scenarios (DATA_W=32):
- ADD: ext-load R2=5 and R3=7; start op=0, ra=1, rb=2, rc=3 -> done 3 cycles later, R1=12, err=0.
- ROR/ROL: R2=0x0000_000F and R3=4; op=6 -> R1=0xF000_0000; op=7 -> R1=0x0000_00F0.
- MUL: R2=0xFFFF_FFFE (-2) and R3=3; op=10 -> done at 4 cycles, HI=0xFFFF_FFFF, LO=0xFFFF_FFFA, R[ra] unchanged.
- R0 and illegal opcode: ra=0 ADD -> R0 reads 0; op=12 -> err=1, no register changes.
- Collisions: start asserted while busy is ignored; ext_we while busy is ignored; ext_we and start in the same cycle use the new value.
- Reset abort: clr low during S_Z -> all outputs 0, no done, state IDLE.
